// File: rtl/cache_data_pkg.sv
// Shared types and default geometry for the L1 data array and its fill engine.
package cache_data_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } fill_state_t;

  // Default geometry; modules derive their own widths from their parameters.
  localparam int unsigned DEF_S_INDEX    = 4;
  localparam int unsigned DEF_WAYS       = 2;
  localparam int unsigned DEF_LINE_BYTES = 32;
  localparam int unsigned DEF_BEAT_BYTES = 8;

  localparam int unsigned BEATS = DEF_LINE_BYTES / DEF_BEAT_BYTES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WAY_W = (DEF_WAYS > 1) ? $clog2(DEF_WAYS) : 1;

  typedef logic [8*DEF_LINE_BYTES-1:0] line_t;

endpackage

// File: rtl/cache_line_fill_buffer.sv
// Beat-serial refill engine: captures the target set/way, assembles the
// burst beat by beat, and raises a one-cycle commit strobe with the full line.
module cache_line_fill_buffer
  import cache_data_pkg::*;
#(
  parameter int unsigned S_INDEX    = 4,
  parameter int unsigned WAY_W_P    = 1,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned BEAT_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fill_start_i,
  input  logic [S_INDEX-1:0]      fill_index_i,
  input  logic [WAY_W_P-1:0]      fill_way_i,
  input  logic                    fill_beat_valid_i,
  input  logic [8*BEAT_BYTES-1:0] fill_beat_data_i,
  output logic                    fill_busy_o,
  output logic                    commit_o,
  output logic [S_INDEX-1:0]      commit_index_o,
  output logic [WAY_W_P-1:0]      commit_way_o,
  output logic [8*LINE_BYTES-1:0] commit_line_o
);

  localparam int unsigned BEATS_L = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned CNT_L   = (BEATS_L > 1) ? $clog2(BEATS_L) : 1;
  localparam int unsigned BEAT_W  = 8 * BEAT_BYTES;
  localparam logic [CNT_L-1:0] LAST_BEAT = CNT_L'(BEATS_L - 1);

  fill_state_t               state_q;
  logic [CNT_L-1:0]          cnt_q;
  logic [S_INDEX-1:0]        index_q;
  logic [WAY_W_P-1:0]        way_q;
  logic [8*LINE_BYTES-1:0]   buf_q;
  logic                      busy_q;
  logic                      commit_q;

  // Fill FSM with registered busy/commit outputs; reset aborts any fill in flight.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      index_q  <= '0;
      way_q    <= '0;
      buf_q    <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          commit_q <= 1'b0;
          if (fill_start_i) begin
            index_q <= fill_index_i;
            way_q   <= fill_way_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (fill_beat_valid_i) begin
            buf_q[cnt_q*BEAT_W +: BEAT_W] <= fill_beat_data_i;
            if (cnt_q == LAST_BEAT) begin
              cnt_q    <= '0;
              commit_q <= 1'b1;
              state_q  <= COMMIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          commit_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          commit_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign fill_busy_o    = busy_q;
  assign commit_o       = commit_q;
  assign commit_index_o = index_q;
  assign commit_way_o   = way_q;
  assign commit_line_o  = buf_q;

endmodule

// File: rtl/cache_line_data_array.sv
// Multi-way L1 data array: registered read with per-byte write-first bypass,
// byte-masked direct write port, and full-line commit from the fill engine.
module cache_line_data_array
  import cache_data_pkg::*;
#(
  parameter int unsigned S_INDEX    = 4,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned BEAT_BYTES = 8,
  localparam int unsigned WW        = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req,
  input  logic [S_INDEX-1:0]      rd_index,
  input  logic [WW-1:0]           rd_way,
  output logic                    rd_valid,
  output logic [8*LINE_BYTES-1:0] rd_data,
  input  logic [LINE_BYTES-1:0]   wr_en,
  input  logic [S_INDEX-1:0]      wr_index,
  input  logic [WW-1:0]           wr_way,
  input  logic [8*LINE_BYTES-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    fill_start,
  input  logic [S_INDEX-1:0]      fill_index,
  input  logic [WW-1:0]           fill_way,
  input  logic                    fill_beat_valid,
  input  logic [8*BEAT_BYTES-1:0] fill_beat_data,
  output logic                    fill_busy,
  output logic                    fill_done
);

  localparam int unsigned SETS   = 1 << S_INDEX;
  localparam int unsigned LINE_W = 8 * LINE_BYTES;

  typedef logic [LINE_W-1:0] line_l_t;

  // Ways beyond WAYS exist only when WAYS is not a power of two.
  function automatic logic way_ok(input logic [WW-1:0] w);
    return 32'(w) < WAYS;
  endfunction

  line_l_t               mem_q [WAYS][SETS];

  logic                  commit;
  logic [S_INDEX-1:0]    commit_index;
  logic [WW-1:0]         commit_way;
  line_l_t               commit_line;

  logic [LINE_BYTES-1:0] w_en;
  logic [S_INDEX-1:0]    w_index;
  logic [WW-1:0]         w_way;
  line_l_t               w_line;
  line_l_t               rd_next;

  logic                  rd_valid_q;
  line_l_t               rd_data_q;

  cache_line_fill_buffer #(
    .S_INDEX   (S_INDEX),
    .WAY_W_P   (WW),
    .LINE_BYTES(LINE_BYTES),
    .BEAT_BYTES(BEAT_BYTES)
  ) u_fill (
    .clk              (clk),
    .rst_n            (rst_n),
    .fill_start_i     (fill_start),
    .fill_index_i     (fill_index),
    .fill_way_i       (fill_way),
    .fill_beat_valid_i(fill_beat_valid),
    .fill_beat_data_i (fill_beat_data),
    .fill_busy_o      (fill_busy),
    .commit_o         (commit),
    .commit_index_o   (commit_index),
    .commit_way_o     (commit_way),
    .commit_line_o    (commit_line)
  );

  assign wr_ready  = ~commit;
  assign fill_done = commit;

  // Single array write port: a commit owns the cycle, otherwise the direct write.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_en    = '0;
    w_index = wr_index;
    w_way   = wr_way;
    w_line  = wr_data;
    if (commit) begin
      w_index = commit_index;
      w_way   = commit_way;
      w_line  = commit_line;
      if (way_ok(commit_way)) w_en = '1;
    end else if (way_ok(wr_way)) begin
      w_en = wr_en;
    end
  end

  // Byte-enabled array write.
  // NOTE: the storage array has no reset; clearing it would need a sweep
  // the cache controller already replaces with valid bits.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(LINE_BYTES); b++) begin
      if (w_en[b]) mem_q[w_way][w_index][8*b +: 8] <= w_line[8*b +: 8];
    end
  end

  // Read data with write-first bypass per byte for a same-cycle write hit.
  always_comb begin
    rd_next = '0;
    if (way_ok(rd_way)) begin
      rd_next = mem_q[rd_way][rd_index];
      if ((w_way == rd_way) && (w_index == rd_index)) begin
        for (int b = 0; b < int'(LINE_BYTES); b++) begin
          if (w_en[b]) rd_next[8*b +: 8] = w_line[8*b +: 8];
        end
      end
    end
  end

  // Read register: valid one cycle after a request, data held between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= rd_next;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_cache_line_data_array.sv
// Directed bench for cache_line_data_array with a line-level reference model.
module tb_cache_line_data_array;
  import cache_data_pkg::*;

  localparam int SI   = DEF_S_INDEX;
  localparam int NW   = DEF_WAYS;
  localparam int LB   = DEF_LINE_BYTES;
  localparam int BB   = DEF_BEAT_BYTES;
  localparam int LW   = 8 * LB;
  localparam int BW   = 8 * BB;
  localparam int NB   = LB / BB;
  localparam int SETS = 1 << SI;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_req;
  logic [SI-1:0]     rd_index;
  logic [WAY_W-1:0]  rd_way;
  logic              rd_valid;
  logic [LW-1:0]     rd_data;
  logic [LB-1:0]     wr_en;
  logic [SI-1:0]     wr_index;
  logic [WAY_W-1:0]  wr_way;
  logic [LW-1:0]     wr_data;
  logic              wr_ready;
  logic              fill_start;
  logic [SI-1:0]     fill_index;
  logic [WAY_W-1:0]  fill_way;
  logic              fill_beat_valid;
  logic [BW-1:0]     fill_beat_data;
  logic              fill_busy;
  logic              fill_done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  cache_line_data_array #(
    .S_INDEX(SI), .WAYS(NW), .LINE_BYTES(LB), .BEAT_BYTES(BB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_index(rd_index), .rd_way(rd_way),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_index(fill_index), .fill_way(fill_way),
    .fill_beat_valid(fill_beat_valid), .fill_beat_data(fill_beat_data),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The array is a plain 2-D table of lines; a fill is a list of beats that
  // becomes one line write the cycle after the last beat arrives.
  bit [LW-1:0]    m_mem [NW][SETS];
  bit             m_busy, m_commit, m_valid, m_was_commit;
  bit [LW-1:0]    m_rdata, m_buf;
  int             m_nbeats;
  bit [SI-1:0]    m_idx;
  bit [WAY_W-1:0] m_way;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_commit = 0; m_valid = 0; m_rdata = '0; m_nbeats = 0;
    end else begin
      m_was_commit = m_commit;
      if (m_commit) begin
        if (int'(m_way) < NW) m_mem[m_way][m_idx] = m_buf;
        m_commit = 0;
        m_busy   = 0;
      end else if (int'(wr_way) < NW) begin
        for (int b = 0; b < LB; b++)
          if (wr_en[b]) m_mem[wr_way][wr_index][8*b +: 8] = wr_data[8*b +: 8];
      end
      if (!m_was_commit) begin
        if (!m_busy) begin
          if (fill_start) begin
            m_busy = 1; m_idx = fill_index; m_way = fill_way; m_nbeats = 0;
          end
        end else if (fill_beat_valid) begin
          m_buf[m_nbeats*BW +: BW] = fill_beat_data;
          m_nbeats++;
          if (m_nbeats == NB) m_commit = 1;
        end
      end
      // A read in the same cycle as a write sees the written bytes.
      m_valid = rd_req;
      if (rd_req) m_rdata = (int'(rd_way) < NW) ? m_mem[rd_way][rd_index] : '0;
    end
  end

  // One compare process, sampling away from the active edge.
  initial forever begin
    @(negedge clk);
    check("rd_valid", LW'(rd_valid), LW'(m_valid));
    if (m_valid) check("rd_data", rd_data, m_rdata);
    check("fill_busy", LW'(fill_busy), LW'(m_busy));
    check("fill_done", LW'(fill_done), LW'(m_commit));
    check("wr_ready", LW'(wr_ready), LW'(!m_commit));
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req = 0; rd_index = '0; rd_way = '0;
    wr_en = '0; wr_index = '0; wr_way = '0; wr_data = '0;
    fill_start = 0; fill_index = '0; fill_way = '0;
    fill_beat_valid = 0; fill_beat_data = '0;
  endtask

  task automatic read(input int idx, input int way);
    rd_req = 1; rd_index = SI'(idx); rd_way = WAY_W'(way);
    step();
    rd_req = 0;
  endtask

  task automatic beat(input logic [7:0] pat);
    fill_beat_valid = 1; fill_beat_data = {BB{pat}};
    step();
    fill_beat_valid = 0;
  endtask

  logic [LW-1:0] pat_p, pat_q, exp_l;

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (3) step();
    check("reset rd_valid", LW'(rd_valid), '0);
    check("reset rd_data", rd_data, '0);
    check("reset fill_busy", LW'(fill_busy), '0);
    rst_n = 1;
    step();

    // Unwritten line reads zero; no request gives rd_valid low.
    read(3, 1);
    check("first read valid", LW'(rd_valid), LW'(1));
    check("first read data", rd_data, '0);
    step();
    check("idle rd_valid", LW'(rd_valid), '0);

    // Byte-masked direct write.
    wr_en = 32'h0000_000F; wr_index = 5; wr_way = 0; wr_data = LW'(32'hDEAD_BEEF);
    step();
    wr_en = '0;
    read(5, 0);
    check("direct write", rd_data, {224'h0, 32'hDEAD_BEEF});

    // Fill set 2 way 1 with a gap; fill_start during FILL is ignored.
    fill_start = 1; fill_index = 2; fill_way = 1;
    step();
    fill_start = 0;
    check("busy after start", LW'(fill_busy), LW'(1));
    beat(8'h11);
    fill_start = 1; fill_index = 9; fill_way = 0;
    beat(8'h22);
    fill_start = 0;
    step();
    check("busy in gap", LW'(fill_busy), LW'(1));
    step();
    beat(8'h33);
    beat(8'h44);
    check("fill_done pulse", LW'(fill_done), LW'(1));
    check("wr_ready in commit", LW'(wr_ready), '0);
    wr_en = '1; wr_index = 7; wr_way = 0; wr_data = {LB{8'h55}};
    step();
    wr_en = '0;
    check("fill_done drops", LW'(fill_done), '0);
    check("busy drops", LW'(fill_busy), '0);
    read(2, 1);
    check("filled line", rd_data, {{BB{8'h44}}, {BB{8'h33}}, {BB{8'h22}}, {BB{8'h11}}});
    read(7, 0);
    check("dropped write", rd_data, '0);
    read(9, 0);
    check("ignored start", rd_data, '0);

    // Same-cycle read and write: full and partial byte bypass.
    pat_p = {8{32'hA5C3_0F96}};
    rd_req = 1; rd_index = 5; rd_way = 0;
    wr_en = '1; wr_index = 5; wr_way = 0; wr_data = pat_p;
    step();
    rd_req = 0; wr_en = '0;
    check("full bypass", rd_data, pat_p);
    rd_req = 1; rd_index = 5; rd_way = 0;
    wr_en = 32'h0000_FF00; wr_index = 5; wr_way = 0; wr_data = {LB{8'h77}};
    step();
    rd_req = 0; wr_en = '0;
    exp_l = pat_p;
    exp_l[64 +: 64] = {8{8'h77}};
    check("partial bypass", rd_data, exp_l);

    // Reset in the middle of a fill leaves the target line untouched.
    pat_q = {LB{8'h3C}};
    wr_en = '1; wr_index = 4; wr_way = 1; wr_data = pat_q;
    step();
    wr_en = '0;
    fill_start = 1; fill_index = 4; fill_way = 1;
    step();
    fill_start = 0;
    beat(8'hAA);
    beat(8'hBB);
    #2 rst_n = 0;
    #1 check("busy after reset", LW'(fill_busy), '0);
    check("no done after reset", LW'(fill_done), '0);
    step();
    rst_n = 1;
    step();
    read(4, 1);
    check("line kept after abort", rd_data, pat_q);

    // A fresh fill completes normally.
    fill_start = 1; fill_index = 4; fill_way = 1;
    step();
    fill_start = 0;
    beat(8'h01);
    beat(8'h02);
    beat(8'h03);
    beat(8'h04);
    check("refill done", LW'(fill_done), LW'(1));
    step();
    read(4, 1);
    check("refill line", rd_data, {{BB{8'h04}}, {BB{8'h03}}, {BB{8'h02}}, {BB{8'h01}}});
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cache_line_data_array.md
Name: cache_line_data_array

Overview:
- Parametrised, multi-way successor of the single-way cache data array.
- Stores WAYS × 2^S_INDEX lines of LINE_BYTES bytes.
- Provides three paths:
  - a registered read port with bypass;
  - a byte-masked direct write port, used for CPU store hits;
  - a beat-serial line-fill engine that assembles a refill burst from memory and commits it as one full-line write.
- Sits between the cache controller and the memory adaptor in the L1 data path.

Parameters:
- S_INDEX, 4, set-index width; set count = 2^S_INDEX.
- WAYS, 2, number of ways; must be ≥ 1.
- LINE_BYTES, 32, bytes per line.
- BEAT_BYTES, 8, bytes per fill beat; LINE_BYTES must be an integer multiple of BEAT_BYTES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request.
- rd_index  in  S_INDEX  read set.
- rd_way  in  $clog2(WAYS) (min 1)  read way.
- rd_valid  out  1  rd_data valid; asserted the cycle after rd_req.
- rd_data  out  8*LINE_BYTES  registered read data.
- wr_en  in  LINE_BYTES  per-byte write enable for the direct write port.
- wr_index  in  S_INDEX  write set.
- wr_way  in  $clog2(WAYS)  write way.
- wr_data  in  8*LINE_BYTES  direct write data.
- wr_ready  out  1  direct write accepted this cycle.
- fill_start  in  1  begin a line fill.
- fill_index  in  S_INDEX  fill target set; captured on start.
- fill_way  in  $clog2(WAYS)  fill target way; captured on start.
- fill_beat_valid  in  1  beat present on fill_beat_data.
- fill_beat_data  in  8*BEAT_BYTES  fill beat; beat 0 carries the lowest bytes.
- fill_busy  out  1  fill engine not IDLE.
- fill_done  out  1  one-cycle pulse in the COMMIT cycle.

Behaviour:
- Reset (async assert, sync deassert by the surrounding reset tree):
  - rd_valid=0, rd_data=0, FSM=IDLE, beat counter=0, assembly buffer cleared.
  - Array contents are not reset; simulation initial value is all-zero.
- Read path:
  - rd_req at edge t → rd_valid=1 and rd_data valid after edge t+1. Latency is 1.
  - rd_valid=0 in cycles without a preceding rd_req.
  - rd_data holds its last value when rd_req=0.
- Read-during-write bypass:
  - Applies when a write (direct or commit) to the same index/way occurs in the same cycle as rd_req.
  - rd_data returns new bytes where the byte is written, old bytes elsewhere (write-first, per byte).
- Direct write:
  - wr_ready=1 in IDLE and FILL, 0 in COMMIT.
  - When wr_ready=1, each byte i with wr_en[i]=1 is written at the edge.
  - When wr_ready=0 the write is dropped. The controller must hold or retry it.
- Fill FSM:
  - IDLE: fill_start → capture index/way, counter=0, go to FILL. fill_beat_valid is ignored in IDLE.
  - FILL: each fill_beat_valid stores the beat at buffer[counter*BEAT_BYTES] and increments the counter.
    - Accepting the last beat (counter = LINE_BYTES/BEAT_BYTES−1) → COMMIT.
    - fill_start is ignored while busy.
  - COMMIT (exactly one cycle): the full line is written to the captured index/way with all bytes enabled, fill_done=1, then → IDLE. The counter wraps to 0.
- Direct write to the set/way being filled during FILL:
  - The write goes to the array.
  - The later commit overwrites those bytes. The controller must not store-hit a line under refill.
- Reset mid-fill aborts the fill. There is no commit and the array is untouched.
- Width rules:
  - Beat count = LINE_BYTES/BEAT_BYTES.
  - Counter width = $clog2(beat count) (min 1).
  - Out-of-range way values (WAYS not a power of 2) are ignored, with no write and rd_data=0.

Decomposition:
- Shared package cache_data_pkg:
  - fill_state_t enum {IDLE, FILL, COMMIT};
  - localparams BEATS, CNT_W, WAY_W;
  - typedef line_t = logic [8*LINE_BYTES-1:0].
- Sub-module cache_line_fill_buffer: FSM, counter, and assembly buffer. It outputs the commit strobe, index, way and line.
- Top level contains the storage array, write mux/priority, and read register with bypass.

Test Plan:
- Reset, then rd_req index 3 way 1 → next cycle rd_valid=1, rd_data=0; with no request, rd_valid=0.
- Direct write wr_en=0x0000_000F, wr_data low word 0xDEADBEEF to set 5 way 0; read next cycle → low 32 bits = 0xDEADBEEF, rest 0.
- fill_start set 2 way 1; 4 beats 0x1111…, 0x2222…, 0x3333…, 0x4444… with a 2-cycle gap after beat 1:
  - fill_busy stays high throughout;
  - fill_done pulses 1 cycle after beat 3;
  - read returns {0x4444…, 0x3333…, 0x2222…, 0x1111…}.
- Same-cycle rd_req and wr_en=0xFFFF_FFFF to the same set/way → rd_data next cycle equals the new wr_data (bypass).
- Direct write presented in the COMMIT cycle → wr_ready=0 and the array is unchanged by it; fill_start during FILL is ignored.
- rst_n low after 2 of 4 beats → fill_busy=0 immediately, the target line keeps its old data, and a new fill then completes normally.
